uart_mmio_ctrl: RTL and testbench
=================================

# uart_mmio_ctrl

Memory-mapped UART controller between the core's data bus and the `Uart` transceiver. It buffers core writes in a TX FIFO and drains them to `Uart` one byte at a time, sequencing `write_enable` against `busy`. It captures received bytes into an RX FIFO and owns the `clk_frequency` configuration register. The top level selects `read_data` from this block whenever `hit` is high, and otherwise from `DMemory`.

## Interface
Parameters:
- `TX_DEPTH`, 8: TX FIFO entries; power of two, ≥2.
- `RX_DEPTH`, 8: RX FIFO entries; power of two, ≥2.
- `BASE_ADDR`, 32'h10010000: register window base.
- `CLK_FREQ_RESET`, 32'hffc0: reset value of `clk_frequency`.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `address`  in  32  core data address.
- `write_data`  in  32  core store data.
- `write_enable`  in  1  core store strobe.
- `write_mask`  in  4  byte lanes; only lane 0 is used.
- `read_enable`  in  1  core load strobe.
- `read_data`  out  32  register read data, combinational from `address`.
- `hit`  out  1  `address` matches a register below.
- `uart_data`  out  8  byte presented to `Uart` data.
- `uart_write_enable`  out  1  one-cycle start pulse to `Uart`.
- `uart_busy`  in  1  `Uart` busy.
- `uart_rx_data`  in  8  `Uart` rx_data.
- `uart_out_valid`  in  1  `Uart` outValid, one-cycle.
- `clk_frequency`  out  32  to `Uart` clk_frequency.

## Operation
Register map (offsets from `BASE_ADDR`):
- 0x000 DATA.
  - Store with `write_mask[0]`: pushes `write_data[7:0]` into the TX FIFO.
  - Load: returns `{24'b0, RX head}` (0 if the RX FIFO is empty). With `read_enable`, pops the RX head.
- 0x005 STATUS, read-only: `{24'b0, 1'b0, uart_busy, tx_drop, rx_overrun, 1'b0, tx_full, tx_empty, rx_not_empty}`.
- 0x008 CTRL, write-only, reads 0. Bits are write-1 actions:
  - bit0: clear `rx_overrun` and `tx_drop`.
  - bit1: flush the TX FIFO.
  - bit2: flush the RX FIFO.
- 0x100 CLKFREQ: read/write 32-bit register driving `clk_frequency`.

FIFO error handling:
- Push to a full TX FIFO: byte is discarded and sticky `tx_drop` is set.
- `uart_out_valid` with the RX FIFO full and no same-cycle pop: byte is discarded and sticky `rx_overrun` is set.
- Pop from an empty RX FIFO: no effect.

Drain FSM states:
- IDLE: if the TX FIFO is non-empty and `uart_busy`=0, go to LOAD.
- LOAD: assert `uart_write_enable` for exactly one cycle with `uart_data` = TX head. Pop the head, go to WAIT_START.
- WAIT_START: when `uart_busy`=1, go to WAIT_DONE. If 4 cycles pass without busy, return to IDLE; the byte counts as sent.
- WAIT_DONE: when `uart_busy`=0, go to IDLE.

`uart_data` holds the last launched byte outside LOAD.

## Timing
- Reset values:
  - FIFOs empty.
  - `rx_overrun` = `tx_drop` = 0.
  - FSM in IDLE.
  - `uart_write_enable` = 0, `uart_data` = 0.
  - `clk_frequency` = `CLK_FREQ_RESET`.
  - `read_data` and `hit` follow `address` combinationally.
- A store to DATA at edge N makes the byte visible in the FIFO after N. If the FIFO was empty and the UART idle, the FSM enters LOAD at N+1 and `uart_write_enable` is high during cycle N+1→N+2, giving a minimum store-to-start latency of 2 cycles.
- Back-to-back bytes: each next LOAD follows the falling edge of `uart_busy` by 1 cycle (WAIT_DONE→IDLE→LOAD).
- Simultaneous events:
  - TX push while LOAD pops a full FIFO: both succeed; count is unchanged and no drop.
  - RX pop and `uart_out_valid` on a full FIFO: both succeed; no overrun.
  - Flush and push in the same cycle: flush wins and the pushed byte is discarded.
  - Clear and a new error in the same cycle: the flag stays set.
- A TX flush during WAIT_START/WAIT_DONE does not abort the in-flight byte; the FSM completes normally.
- Pointers wrap modulo depth. Full/empty are distinguished by an extra pointer bit (width `$clog2(DEPTH)+1`).
- Asserting `rst` mid-transmission returns the block to its reset state immediately; `uart_write_enable` drops asynchronously.

## Structure
- Package `uart_mmio_pkg`:
  - Register offsets `OFS_DATA`, `OFS_STATUS`, `OFS_CTRL`, `OFS_CLKFREQ`.
  - STATUS bit indices.
  - `typedef enum logic [1:0] {IDLE, LOAD, WAIT_START, WAIT_DONE} drain_state_t`.
- One sub-module, `sync_fifo` (parameters DEPTH, WIDTH; push/pop/flush/full/empty/head), instantiated twice (TX, RX).
- Address decode, the sticky flags, CLKFREQ and the drain FSM live in `uart_mmio_ctrl`.

## Test plan
- Reset, then read STATUS → 0x02 (`tx_empty`); read CLKFREQ → 0x0000ffc0.
- Store 0x41, 0x42, 0x43 to DATA back-to-back; model busy high 10 cycles per byte → exactly three `uart_write_enable` pulses carrying 0x41, 0x42, 0x43, each ≥1 cycle after busy falls, with the first 2 cycles after the store.
- Store 9 bytes with busy held high (depth 8) → `tx_full`=1 and `tx_drop`=1. Write CTRL=0x1 → `tx_drop`=0. Release busy → 8 bytes emitted.
- Drive 9 `uart_out_valid` pulses (0x10..0x18) with no loads → `rx_overrun`=1. Eight loads with `read_enable` return 0x10..0x17, then `rx_not_empty`=0.
- With the RX FIFO full, pop and `uart_out_valid` (0x55) in the same cycle → `rx_overrun` stays 0 and 0x55 is read last.
- Store 0x99, assert `rst` while the FSM is in WAIT_DONE → all outputs are at reset values immediately, no further pulses, and STATUS = 0x02.

Source files
------------

// File: rtl/uart_mmio_pkg.sv
// Shared register map, STATUS/CTRL bit positions and drain FSM encoding
// for the memory-mapped UART controller.
package uart_mmio_pkg;

  localparam logic [31:0] OFS_DATA    = 32'h0000_0000;
  localparam logic [31:0] OFS_STATUS  = 32'h0000_0005;
  localparam logic [31:0] OFS_CTRL    = 32'h0000_0008;
  localparam logic [31:0] OFS_CLKFREQ = 32'h0000_0100;

  localparam int ST_RX_NOT_EMPTY = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_TX_FULL      = 2;
  localparam int ST_RX_OVERRUN   = 4;
  localparam int ST_TX_DROP      = 5;
  localparam int ST_UART_BUSY    = 6;

  localparam int CTRL_CLR_ERR  = 0;
  localparam int CTRL_FLUSH_TX = 1;
  localparam int CTRL_FLUSH_RX = 2;

  // Last count value in WAIT_START before giving up on busy (4 cycles total).
  localparam logic [1:0] START_LAST = 2'd3;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_START, WAIT_DONE} drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; a push into a full FIFO is accepted only
// when a pop retires the head in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: non-blocking assignments for all sequential state so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: TX/RX FIFOs, sticky error flags, CLKFREQ
// register and the FSM that hands TX bytes to the transceiver one at a time.
module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter int          TX_DEPTH       = 8,
  parameter int          RX_DEPTH       = 8,
  parameter logic [31:0] BASE_ADDR      = 32'h1001_0000,
  parameter logic [31:0] CLK_FREQ_RESET = 32'h0000_ffc0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  input  logic [3:0]  write_mask,
  input  logic        read_enable,
  output logic [31:0] read_data,
  output logic        hit,
  output logic [7:0]  uart_data,
  output logic        uart_write_enable,
  input  logic        uart_busy,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_out_valid,
  output logic [31:0] clk_frequency
);

  logic sel_data, sel_status, sel_ctrl, sel_clkfreq;
  logic tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic rx_pop, rx_flush, rx_full, rx_empty;
  logic ctrl_wr, clr_err, tx_drop, rx_overrun;
  logic [7:0] tx_head, rx_head;
  logic [1:0] start_cnt;
  logic [2:0] unused_mask;
  drain_state_t state;

  assign unused_mask = write_mask[3:1];

  assign sel_data    = (address == BASE_ADDR + OFS_DATA);
  assign sel_status  = (address == BASE_ADDR + OFS_STATUS);
  assign sel_ctrl    = (address == BASE_ADDR + OFS_CTRL);
  assign sel_clkfreq = (address == BASE_ADDR + OFS_CLKFREQ);
  assign hit         = sel_data | sel_status | sel_ctrl | sel_clkfreq;

  assign tx_push  = write_enable && sel_data && write_mask[0];
  assign ctrl_wr  = write_enable && sel_ctrl;
  assign clr_err  = ctrl_wr && write_data[CTRL_CLR_ERR];
  assign tx_flush = ctrl_wr && write_data[CTRL_FLUSH_TX];
  assign rx_flush = ctrl_wr && write_data[CTRL_FLUSH_RX];
  assign rx_pop   = read_enable && sel_data;
  assign tx_pop   = (state == LOAD);

  sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
    .din(write_data[7:0]), .full(tx_full), .empty(tx_empty), .head(tx_head)
  );

  sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(uart_out_valid), .pop(rx_pop), .flush(rx_flush),
    .din(uart_rx_data), .full(rx_full), .empty(rx_empty), .head(rx_head)
  );

  // A new error beats a same-cycle clear so no event is ever lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_drop    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (tx_push && tx_full && !tx_pop)                        tx_drop <= 1'b1;
      else if (clr_err)                                         tx_drop <= 1'b0;
      if (uart_out_valid && rx_full && !rx_pop && !rx_flush)    rx_overrun <= 1'b1;
      else if (clr_err)                                         rx_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          clk_frequency <= CLK_FREQ_RESET;
    else if (write_enable && sel_clkfreq) clk_frequency <= write_data;
  end

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    read_data = '0;
    if (sel_data && !rx_empty) begin
      read_data[7:0] = rx_head;
    end else if (sel_status) begin
      read_data[ST_RX_NOT_EMPTY] = !rx_empty;
      read_data[ST_TX_EMPTY]     = tx_empty;
      read_data[ST_TX_FULL]      = tx_full;
      read_data[ST_RX_OVERRUN]   = rx_overrun;
      read_data[ST_TX_DROP]      = tx_drop;
      read_data[ST_UART_BUSY]    = uart_busy;
    end else if (sel_clkfreq) begin
      read_data = clk_frequency;
    end
  end

  // The start pulse and data are registered on the IDLE->LOAD edge, so the
  // pulse coincides with LOAD and uart_data holds the byte afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      uart_write_enable <= 1'b0;
      uart_data         <= '0;
      start_cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!tx_empty && !uart_busy) begin
            state             <= LOAD;
            uart_write_enable <= 1'b1;
            uart_data         <= tx_head;
          end
        end
        LOAD: begin
          uart_write_enable <= 1'b0;
          start_cnt         <= '0;
          state             <= WAIT_START;
        end
        WAIT_START: begin
          if (uart_busy)                     state <= WAIT_DONE;
          else if (start_cnt == START_LAST)  state <= IDLE;
          else                               start_cnt <= start_cnt + 1'b1;
        end
        WAIT_DONE: begin
          if (!uart_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench: reset-state register table, directed UART/FIFO
// sequences, a randomized queue-model run and mid-transfer reset checks.
module tb_uart_mmio_ctrl;

  localparam logic [31:0] BASE      = 32'h1001_0000;
  localparam logic [31:0] A_DATA    = BASE + 32'h000;
  localparam logic [31:0] A_STATUS  = BASE + 32'h005;
  localparam logic [31:0] A_CTRL    = BASE + 32'h008;
  localparam logic [31:0] A_CLKFREQ = BASE + 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic        write_enable = 1'b0;
  logic [3:0]  write_mask = '0;
  logic        read_enable = 1'b0;
  logic [31:0] read_data;
  logic        hit;
  logic [7:0]  uart_data;
  logic        uart_write_enable;
  logic        uart_busy;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_out_valid = 1'b0;
  logic [31:0] clk_frequency;

  logic force_busy = 1'b0;
  logic model_busy = 1'b0;
  logic model_en   = 1'b1;
  assign uart_busy = force_busy | model_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int busy_left = 0;
  int last_fall = 0;
  bit have_fall = 0;
  logic prev_we = 1'b0;
  logic [7:0] pulses[$];
  int         pulse_cyc[$];

  uart_mmio_ctrl dut (
    .clk(clk), .rst(rst), .address(address), .write_data(write_data),
    .write_enable(write_enable), .write_mask(write_mask), .read_enable(read_enable),
    .read_data(read_data), .hit(hit), .uart_data(uart_data),
    .uart_write_enable(uart_write_enable), .uart_busy(uart_busy),
    .uart_rx_data(uart_rx_data), .uart_out_valid(uart_out_valid),
    .clk_frequency(clk_frequency)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transceiver model: records each start pulse and stays busy 10 cycles.
  always @(negedge clk) begin
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        model_busy = 1'b0;
        last_fall  = cyc;
        have_fall  = 1;
      end
    end
    if (uart_write_enable && !rst) begin
      check("pulse_while_busy", {31'b0, uart_busy}, 32'h0);
      check("pulse_width", {31'b0, prev_we}, 32'h0);
      if (have_fall) check("pulse_after_fall", {31'b0, (cyc - last_fall) >= 2}, 32'h1);
      pulses.push_back(uart_data);
      pulse_cyc.push_back(cyc);
      if (model_en) begin
        model_busy = 1'b1;
        busy_left  = 10;
      end
    end
    prev_we = uart_write_enable;
  end

  task automatic wr(logic [31:0] a, logic [31:0] d);
    address = a; write_data = d; write_mask = 4'hf; write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic rd_chk(string name, logic [31:0] a, logic pop, logic [31:0] exp);
    address = a; read_enable = pop;
    #1 check(name, read_data, exp);
    @(negedge clk);
    read_enable = 1'b0;
  endtask

  task automatic rx_byte(logic [7:0] b);
    uart_rx_data = b; uart_out_valid = 1'b1;
    @(negedge clk);
    uart_out_valid = 1'b0;
  endtask

  task automatic wait_pulses(int n, int budget);
    int k = 0;
    while (pulses.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  function automatic logic [31:0] status_of(bit busy, bit drop, bit ovr, int txn, int rxn);
    return {24'b0, 1'b0, busy, drop, ovr, 1'b0, txn == 8, txn == 0, rxn != 0};
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_data;
    logic        exp_hit;
  } reg_vec_t;

  reg_vec_t   vecs[8];
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  bit drop_m, ovr_m;

  initial begin
    vecs[0] = '{A_DATA,         32'h0,         1'b1};
    vecs[1] = '{A_STATUS,       32'h2,         1'b1};
    vecs[2] = '{A_CTRL,         32'h0,         1'b1};
    vecs[3] = '{A_CLKFREQ,      32'h0000ffc0,  1'b1};
    vecs[4] = '{BASE + 32'h1,   32'h0,         1'b0};
    vecs[5] = '{BASE + 32'h4,   32'h0,         1'b0};
    vecs[6] = '{BASE + 32'h104, 32'h0,         1'b0};
    vecs[7] = '{32'h0,          32'h0,         1'b0};

    repeat (3) @(negedge clk);
    check("rst_we", {31'b0, uart_write_enable}, 32'h0);
    check("rst_data", {24'b0, uart_data}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_clkfreq", clk_frequency, 32'h0000ffc0);
    foreach (vecs[i]) begin
      address = vecs[i].addr;
      #1;
      check($sformatf("tbl_data%0d", i), read_data, vecs[i].exp_data);
      check($sformatf("tbl_hit%0d", i), {31'b0, hit}, {31'b0, vecs[i].exp_hit});
    end
    @(negedge clk);

    // Three back-to-back stores drained through the busy model.
    begin
      int c0;
      pulses.delete(); pulse_cyc.delete();
      c0 = cyc;
      wr(A_DATA, 32'h41); wr(A_DATA, 32'h42); wr(A_DATA, 32'h43);
      wait_pulses(3, 200);
      repeat (30) @(negedge clk);
      check("b2b_count", pulses.size(), 3);
      if (pulses.size() == 3) begin
        check("b2b_byte0", {24'b0, pulses[0]}, 32'h41);
        check("b2b_byte1", {24'b0, pulses[1]}, 32'h42);
        check("b2b_byte2", {24'b0, pulses[2]}, 32'h43);
        check("b2b_latency", pulse_cyc[0] - c0, 2);
      end
      check("b2b_hold_data", {24'b0, uart_data}, 32'h43);
      rd_chk("b2b_status", A_STATUS, 1'b0, 32'h02);
    end

    // TX overflow with busy held, clear, then release.
    force_busy = 1'b1;
    for (int i = 0; i < 9; i++) wr(A_DATA, 32'h60 + i);
    rd_chk("txfull_status", A_STATUS, 1'b0, 32'h64);
    wr(A_CTRL, 32'h1);
    rd_chk("txclr_status", A_STATUS, 1'b0, 32'h44);
    pulses.delete(); pulse_cyc.delete();
    force_busy = 1'b0;
    wait_pulses(8, 400);
    repeat (30) @(negedge clk);
    check("txdrain_count", pulses.size(), 8);
    for (int i = 0; i < 8 && i < pulses.size(); i++)
      check($sformatf("txdrain_byte%0d", i), {24'b0, pulses[i]}, 32'h60 + i);

    // RX overrun and in-order pops.
    for (int i = 0; i < 9; i++) rx_byte(8'h10 + 8'(i));
    rd_chk("rxovr_status", A_STATUS, 1'b0, 32'h13);
    rd_chk("rx_peek", A_DATA, 1'b0, 32'h10);
    for (int i = 0; i < 8; i++) rd_chk($sformatf("rx_pop%0d", i), A_DATA, 1'b1, 32'h10 + i);
    rd_chk("rx_empty_status", A_STATUS, 1'b0, 32'h12);
    rd_chk("rx_empty_read", A_DATA, 1'b1, 32'h0);
    wr(A_CTRL, 32'h1);
    rd_chk("rx_clr_status", A_STATUS, 1'b0, 32'h02);

    // Same-cycle pop and receive on a full RX FIFO.
    for (int i = 0; i < 8; i++) rx_byte(8'h20 + 8'(i));
    address = A_DATA; read_enable = 1'b1; uart_rx_data = 8'h55; uart_out_valid = 1'b1;
    #1 check("rxsim_head", read_data, 32'h20);
    @(negedge clk);
    read_enable = 1'b0; uart_out_valid = 1'b0;
    rd_chk("rxsim_status", A_STATUS, 1'b0, 32'h03);
    for (int i = 1; i < 8; i++) rd_chk($sformatf("rxsim_pop%0d", i), A_DATA, 1'b1, 32'h20 + i);
    rd_chk("rxsim_last", A_DATA, 1'b1, 32'h55);

    // RX flush, CLKFREQ, and WAIT_START timeout with a silent transceiver.
    rx_byte(8'h31); rx_byte(8'h32);
    wr(A_CTRL, 32'h4);
    rd_chk("rxflush_status", A_STATUS, 1'b0, 32'h02);
    wr(A_CLKFREQ, 32'h1234_5678);
    rd_chk("clkfreq_read", A_CLKFREQ, 1'b0, 32'h1234_5678);
    check("clkfreq_port", clk_frequency, 32'h1234_5678);
    model_en = 1'b0;
    pulses.delete(); pulse_cyc.delete();
    wr(A_DATA, 32'hA1); wr(A_DATA, 32'hA2);
    wait_pulses(2, 100);
    check("timeout_count", pulses.size(), 2);
    if (pulses.size() == 2) begin
      check("timeout_byte1", {24'b0, pulses[1]}, 32'hA2);
      check("timeout_gap", {31'b0, (pulse_cyc[1] - pulse_cyc[0]) inside {[5:7]}}, 32'h1);
    end
    model_en = 1'b1;
    repeat (5) @(negedge clk);

    // Randomized register traffic against queue model, TX held off by busy.
    force_busy = 1'b1;
    txq.delete(); rxq.delete(); drop_m = 0; ovr_m = 0;
    for (int n = 0; n < 120; n++) begin
      int op;
      logic [7:0] b;
      logic [31:0] exp;
      op = $urandom_range(0, 9);
      b = 8'($urandom);
      case (op)
        0, 1, 2: begin
          if (txq.size() < 8) txq.push_back(b); else drop_m = 1;
          wr(A_DATA, {24'hABCDEF, b});
        end
        3, 4: begin
          if (rxq.size() < 8) rxq.push_back(b); else ovr_m = 1;
          rx_byte(b);
        end
        5, 6: begin
          exp = (rxq.size() != 0) ? {24'b0, rxq.pop_front()} : 32'h0;
          rd_chk("rnd_pop", A_DATA, 1'b1, exp);
        end
        7: rd_chk("rnd_status", A_STATUS, 1'b0, status_of(1, drop_m, ovr_m, txq.size(), rxq.size()));
        8: begin
          logic [2:0] c;
          c = 3'($urandom_range(1, 7));
          if (c[0]) begin drop_m = 0; ovr_m = 0; end
          if (c[1]) txq.delete();
          if (c[2]) rxq.delete();
          wr(A_CTRL, {29'b0, c});
        end
        default: begin
          exp = (rxq.size() != 0) ? {24'b0, rxq[0]} : 32'h0;
          rd_chk("rnd_peek", A_DATA, 1'b0, exp);
        end
      endcase
    end
    rd_chk("rnd_final_status", A_STATUS, 1'b0, status_of(1, drop_m, ovr_m, txq.size(), rxq.size()));
    expq = txq;
    pulses.delete(); pulse_cyc.delete();
    force_busy = 1'b0;
    wait_pulses(expq.size(), 400);
    repeat (30) @(negedge clk);
    check("rnd_drain_count", pulses.size(), expq.size());
    for (int i = 0; i < expq.size() && i < pulses.size(); i++)
      check($sformatf("rnd_drain%0d", i), {24'b0, pulses[i]}, {24'b0, expq[i]});
    while (rxq.size() != 0) rd_chk("rnd_rx_tail", A_DATA, 1'b1, {24'b0, rxq.pop_front()});
    wr(A_CTRL, 32'h1);

    // Reset while the transfer is in WAIT_DONE.
    wr(A_CLKFREQ, 32'h0000_ABCD);
    pulses.delete(); pulse_cyc.delete();
    wr(A_DATA, 32'h99);
    wait_pulses(1, 50);
    check("rst_wd_pulse", pulses.size(), 1);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1; busy_left = 0; model_busy = 1'b0;
    address = A_STATUS;
    #1;
    check("rst_wd_we", {31'b0, uart_write_enable}, 32'h0);
    check("rst_wd_data", {24'b0, uart_data}, 32'h0);
    check("rst_wd_clkfreq", clk_frequency, 32'h0000ffc0);
    check("rst_wd_status", read_data, 32'h02);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("rst_wd_no_pulse", pulses.size(), 1);

    // Reset during the LOAD cycle drops the start pulse asynchronously.
    begin
      bit seen = 0;
      wr(A_DATA, 32'h77);
      for (int k = 0; k < 20 && !seen; k++) begin
        @(posedge clk);
        #1;
        if (uart_write_enable) seen = 1;
      end
      check("rst_ld_seen", {31'b0, seen}, 32'h1);
      rst = 1'b1; busy_left = 0; model_busy = 1'b0;
      #1 check("rst_ld_we", {31'b0, uart_write_enable}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      rd_chk("rst_ld_status", A_STATUS, 1'b0, 32'h02);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
